// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus for the 5-stage MIPS pipeline.
//
// Groups the decode/execute hazard inputs and the pipeline control outputs of
// pipe_hazard_ctrl. The clock and reset are not part of the bus.
//   master : pipeline side; drives the ID/EX fields and consumes the controls.
//   slave  : hazard controller; consumes the ID/EX fields and drives the controls.
//
// Signals:
//   ID_Rs, ID_Rt         rs/rt specifiers of the instruction in ID
//   ID_UsesRs, ID_UsesRt ID instruction actually reads rs/rt
//   ID_MulDiv            ID instruction is mult/multu/div/divu
//   ID_ReadsHiLo         ID instruction is mfhi/mflo
//   EX_MemRead, EX_Rt    load in EX and its destination register
//   EX_BranchTaken       branch/jump resolved taken in EX
//   PCWrite, IFIDWrite   PC and IF/ID load enables
//   IFIDFlush, IDEXFlush turn IF/ID into a NOP / insert a bubble into ID/EX
//   MDStart, MDBusy      mult/div start pulse and busy status
//   StallCount           saturating count of stall cycles
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] ID_Rs;
  logic [REG_ADDR_W-1:0] ID_Rt;
  logic                  ID_UsesRs;
  logic                  ID_UsesRt;
  logic                  ID_MulDiv;
  logic                  ID_ReadsHiLo;
  logic                  EX_MemRead;
  logic [REG_ADDR_W-1:0] EX_Rt;
  logic                  EX_BranchTaken;

  logic                  PCWrite;
  logic                  IFIDWrite;
  logic                  IFIDFlush;
  logic                  IDEXFlush;
  logic                  MDStart;
  logic                  MDBusy;
  logic [31:0]           StallCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_MulDiv, ID_ReadsHiLo,
    output EX_MemRead, EX_Rt, EX_BranchTaken,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDStart, MDBusy, StallCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_MulDiv, ID_ReadsHiLo,
    input  EX_MemRead, EX_Rt, EX_BranchTaken,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDStart, MDBusy, StallCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline.
//
// Produces the PC and IF/ID write enables plus the IF/ID and ID/EX flush
// controls from the load-use hazard, taken-branch resolution and the state of
// a multi-cycle mult/div unit. A taken branch wins over every stall source.
// The mult/div unit is sequenced by a two-state machine with a down-counter;
// mfhi/mflo and further mult/div instructions stall in ID while it is busy.
//
// Parameters:
//   REG_ADDR_W  register specifier width (must match the bus)
//   MD_CYCLES   mult/div busy latency in cycles, 1..63
//   CNT_W       busy-counter width, 2**CNT_W > MD_CYCLES
//
// Ports:
//   Clk    clock, all state changes on posedge
//   Reset  asynchronous active-low reset; forces every control output low
//   bus    slave side of pipe_hazard_ctrl_if (hazard inputs, control outputs)
//
// Control outputs are combinational so the PC and pipeline registers act on
// them in the same cycle; only the MD state, busy counter and StallCount are
// registered.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MD_CYCLES  = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                 Clk,
  input  logic                 Reset,
  pipe_hazard_ctrl_if.slave    bus
);

  typedef enum logic {
    StIdle,
    StBusy
  } md_state_e;

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MD_CYCLES - 1);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      stall_cnt_q;

  logic busy;
  logic rs_match;
  logic rt_match;
  logic lu;
  logic mdh;
  logic stall;
  logic md_start;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_flush;

  assign busy = (state_q == StBusy);

  // A load into $zero never produces a usable value, so it never stalls.
  assign rs_match = bus.ID_UsesRs & (bus.ID_Rs == bus.EX_Rt);
  assign rt_match = bus.ID_UsesRt & (bus.ID_Rt == bus.EX_Rt);
  assign lu       = bus.EX_MemRead & (bus.EX_Rt != '0) & (rs_match | rt_match);

  // HI/LO readers and a second mult/div wait for the unit to drain.
  assign mdh = busy & (bus.ID_ReadsHiLo | bus.ID_MulDiv);

  // Stalls are only counted when no taken branch overrides them.
  assign stall = Reset & ~bus.EX_BranchTaken & (lu | mdh);

  assign md_start = Reset & bus.ID_MulDiv & (state_q == StIdle) & ~bus.EX_BranchTaken & ~lu;

  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (Reset) begin
      if (bus.EX_BranchTaken) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu | mdh) begin
        idex_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  // MD sequencer plus stall statistics. A taken branch does not abort a
  // running operation; only reset returns the unit to idle early.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (md_start) begin
            state_q <= StBusy;
            cnt_q   <= CntLoad;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase

      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.IFIDWrite  = ifid_write;
  assign bus.IFIDFlush  = ifid_flush;
  assign bus.IDEXFlush  = idex_flush;
  assign bus.MDStart    = md_start;
  assign bus.MDBusy     = Reset & busy;
  assign bus.StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timestamp-based model.
module tb_pipe_hazard_ctrl;
  localparam int unsigned MD = 12;

  logic Clk;
  logic Reset;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

  pipe_hazard_ctrl #(
    .REG_ADDR_W(5),
    .MD_CYCLES (MD),
    .CNT_W     (6)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit br, input bit mr, input int ert, input int rs, input int rt,
                        input bit urs, input bit urt, input bit md, input bit hl);
    bus.EX_BranchTaken = br;
    bus.EX_MemRead     = mr;
    bus.EX_Rt          = 5'(ert);
    bus.ID_Rs          = 5'(rs);
    bus.ID_Rt          = 5'(rt);
    bus.ID_UsesRs      = urs;
    bus.ID_UsesRt      = urt;
    bus.ID_MulDiv      = md;
    bus.ID_ReadsHiLo   = hl;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: the unit is busy in cycle c when a start happened in some
  // cycle s with s < c <= s + MD; md_done holds the last busy cycle number.
  int     cyc     = 0;
  int     md_done = -1;
  longint stall_m = 0;
  bit     m_busy, m_lu, m_mdh, m_start;
  bit     e_pc, e_ifw, e_iff, e_idf;

  function automatic bit id_reads(input logic [4:0] r);
    return (bus.ID_UsesRs && bus.ID_Rs == r) || (bus.ID_UsesRt && bus.ID_Rt == r);
  endfunction

  always @(negedge Clk) begin
    if (!Reset) begin
      e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 0; m_start = 0; m_busy = 0;
      stall_m = 0;
      md_done = cyc;
    end else begin
      m_busy  = (cyc <= md_done);
      m_lu    = bus.EX_MemRead && (bus.EX_Rt != 0) && id_reads(bus.EX_Rt);
      m_mdh   = m_busy && (bus.ID_ReadsHiLo || bus.ID_MulDiv);
      m_start = bus.ID_MulDiv && !m_busy && !bus.EX_BranchTaken && !m_lu;
      if (bus.EX_BranchTaken) begin
        e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 1;
      end else if (m_lu || m_mdh) begin
        e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 1;
      end else begin
        e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0;
      end
    end
    chk("m_PCWrite",    32'(bus.PCWrite),   32'(e_pc));
    chk("m_IFIDWrite",  32'(bus.IFIDWrite), 32'(e_ifw));
    chk("m_IFIDFlush",  32'(bus.IFIDFlush), 32'(e_iff));
    chk("m_IDEXFlush",  32'(bus.IDEXFlush), 32'(e_idf));
    chk("m_MDStart",    32'(bus.MDStart),   32'(m_start));
    chk("m_MDBusy",     32'(bus.MDBusy),    32'(m_busy));
    chk("m_StallCount", bus.StallCount,     32'(stall_m));
    if (Reset) begin
      if (!bus.EX_BranchTaken && (m_lu || m_mdh) && stall_m < 64'hFFFF_FFFF) stall_m++;
      if (m_start) md_done = cyc + MD;
    end
    cyc++;
  end

  initial begin
    Reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_PCWrite",    32'(bus.PCWrite),   32'd0);
    chk("rst_IFIDWrite",  32'(bus.IFIDWrite), 32'd0);
    chk("rst_MDBusy",     32'(bus.MDBusy),    32'd0);
    chk("rst_StallCount", bus.StallCount,     32'd0);
    next_cycle();
    next_cycle();
    Reset = 1'b1;

    // Load-use on rs.
    next_cycle();
    set_in(0, 1, 8, 8, 0, 1, 0, 0, 0);
    #3;
    chk("lu_PCWrite",   32'(bus.PCWrite),   32'd0);
    chk("lu_IFIDWrite", 32'(bus.IFIDWrite), 32'd0);
    chk("lu_IDEXFlush", 32'(bus.IDEXFlush), 32'd1);
    chk("lu_Stall0",    bus.StallCount,     32'd0);
    next_cycle();
    set_in(0, 0, 8, 8, 0, 1, 0, 0, 0);
    #3;
    chk("lu_release_PCWrite", 32'(bus.PCWrite), 32'd1);
    chk("lu_Stall1",          bus.StallCount,   32'd1);

    // A load into $zero never stalls.
    next_cycle();
    set_in(0, 1, 0, 0, 0, 1, 0, 0, 0);
    #3;
    chk("zero_PCWrite", 32'(bus.PCWrite), 32'd1);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("zero_Stall", bus.StallCount, 32'd1);

    // Taken branch beats load-use and suppresses the mult/div start.
    next_cycle();
    set_in(1, 1, 9, 0, 9, 0, 1, 1, 0);
    #3;
    chk("br_PCWrite",   32'(bus.PCWrite),   32'd1);
    chk("br_IFIDFlush", 32'(bus.IFIDFlush), 32'd1);
    chk("br_IDEXFlush", 32'(bus.IDEXFlush), 32'd1);
    chk("br_MDStart",   32'(bus.MDStart),   32'd0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("br_Stall",  bus.StallCount,  32'd1);
    chk("br_MDBusy", 32'(bus.MDBusy), 32'd0);

    // Mult/div latency with a dependent mfhi held in ID.
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #3;
    chk("lat_MDStart", 32'(bus.MDStart), 32'd1);
    for (int i = 1; i <= MD; i++) begin
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #3;
      chk("lat_MDBusy",  32'(bus.MDBusy),  32'd1);
      chk("lat_PCWrite", 32'(bus.PCWrite), 32'd0);
    end
    next_cycle();
    #3;
    chk("lat_done_MDBusy",  32'(bus.MDBusy),  32'd0);
    chk("lat_done_PCWrite", 32'(bus.PCWrite), 32'd1);
    chk("lat_Stall",        bus.StallCount,   32'(1 + MD));

    // Back-to-back mult/div: the second one waits out the first.
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #3;
    chk("b2b_MDStart1", 32'(bus.MDStart), 32'd1);
    for (int i = 1; i <= MD; i++) begin
      next_cycle();
      #3;
      chk("b2b_stall_PCWrite", 32'(bus.PCWrite), 32'd0);
      chk("b2b_stall_MDStart", 32'(bus.MDStart), 32'd0);
    end
    next_cycle();
    #3;
    chk("b2b_MDStart2", 32'(bus.MDStart), 32'd1);
    chk("b2b_idle",     32'(bus.MDBusy),  32'd0);
    chk("b2b_Stall",    bus.StallCount,   32'(1 + 2 * MD));
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("b2b_rebusy", 32'(bus.MDBusy), 32'd1);

    // Asynchronous reset in the middle of the busy window.
    next_cycle();
    #1;
    Reset = 1'b0;
    #1;
    chk("arst_MDBusy",  32'(bus.MDBusy),  32'd0);
    chk("arst_PCWrite", 32'(bus.PCWrite), 32'd0);
    chk("arst_Stall",   bus.StallCount,   32'd0);
    next_cycle();
    Reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #3;
    chk("arst_hilo_PCWrite", 32'(bus.PCWrite), 32'd1);
    chk("arst_hilo_MDStart", 32'(bus.MDStart), 32'd0);
    chk("arst_hilo_MDBusy",  32'(bus.MDBusy),  32'd0);

    // Randomized traffic; the negedge model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      Reset = ($urandom_range(0, 399) != 0);
      set_in($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0);
    end
    next_cycle();
    Reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
